seg7_capture_decoder: RTL and testbench

Inverse of the team's hex-to-7-segment encoding. Samples the segment and digit-select lines of a multiplexed, active-high gfedcba 7-segment display. Once a pattern has been stable for a programmable number of cycles, decodes it back to a 4-bit hex digit and stores one value per digit position. Used as a loop-back checker and readback path for display drivers in the VGA/FPGA design.

---
 rtl/seg7_pkg.sv | 60 ++++++
 rtl/seg7_to_hex.sv | 20 ++
 rtl/seg7_capture_decoder.sv | 107 ++++++++++
 tb/tb_seg7_capture_decoder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared gfedcba 7-segment code table and its reverse decode.
// The display encoder and the capture decoder both use this package.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] nibble;
  } seg7_dec_t;

  function automatic seg7_dec_t seg7_decode(input logic [6:0] seg);
    seg7_dec_t d;
    d.legal  = 1'b1;
    d.blank  = 1'b0;
    d.nibble = 4'h0;
    case (seg)
      SEG_0:     d.nibble = 4'h0;
      SEG_1:     d.nibble = 4'h1;
      SEG_2:     d.nibble = 4'h2;
      SEG_3:     d.nibble = 4'h3;
      SEG_4:     d.nibble = 4'h4;
      SEG_5:     d.nibble = 4'h5;
      SEG_6:     d.nibble = 4'h6;
      SEG_7:     d.nibble = 4'h7;
      SEG_8:     d.nibble = 4'h8;
      SEG_9:     d.nibble = 4'h9;
      SEG_A:     d.nibble = 4'hA;
      SEG_B:     d.nibble = 4'hB;
      SEG_C:     d.nibble = 4'hC;
      SEG_D:     d.nibble = 4'hD;
      SEG_E:     d.nibble = 4'hE;
      SEG_F:     d.nibble = 4'hF;
      SEG_BLANK: begin
        d.legal = 1'b0;
        d.blank = 1'b1;
      end
      default:   d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational reverse of the hex-to-7-segment encoder.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic       blank,
  output logic [3:0] nibble
);

  seg7_dec_t dec;

  always_comb begin
    dec    = seg7_decode(seg);
    legal  = dec.legal;
    blank  = dec.blank;
    nibble = dec.nibble;
  end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Samples a multiplexed 7-segment bus, waits for a stable pattern, and
// stores the decoded hex digit for the selected position.
module seg7_capture_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [6:0]              i_seg_gfedcba,
  input  logic [NUM_DIGITS-1:0]   i_digit_sel,
  output logic [4*NUM_DIGITS-1:0] o_value,
  output logic [NUM_DIGITS-1:0]   o_digit_valid,
  output logic                    o_update,
  output logic                    o_error,
  output logic                    o_error_sticky
);

  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam int SW = NUM_DIGITS + 7;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] sel);
    return (sel != '0) && ((sel & (sel - 1'b1)) == '0);
  endfunction

  function automatic logic [IW-1:0] onehot_index(input logic [NUM_DIGITS-1:0] sel);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel[i]) idx = IW'(i);
    end
    return idx;
  endfunction

  logic [SW-1:0]         in_w;
  logic [SW-1:0]         s_q;
  logic [SW-1:0]         p_q;
  logic [CW-1:0]         cnt_q;
  logic                  lock_q;
  logic [NUM_DIGITS-1:0] s_sel;
  logic [6:0]            s_seg;
  logic                  accept;
  logic                  legal;
  logic                  blank;
  logic [3:0]            nibble;
  logic [IW-1:0]         idx;

  assign in_w  = {i_digit_sel, i_seg_gfedcba};
  assign s_sel = s_q[SW-1:7];
  assign s_seg = s_q[6:0];
  assign idx   = onehot_index(s_sel);

  // Count tracks the sample about to land in S against the one landing in P,
  // so accept fires STABLE_CYCLES-1 edges after first capture.
  assign accept = (cnt_q == CNT_MAX) && !lock_q && (s_q == p_q) && is_onehot(s_sel);

  seg7_to_hex u_dec (
    .seg    (s_seg),
    .legal  (legal),
    .blank  (blank),
    .nibble (nibble)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s_q            <= '0;
      p_q            <= '0;
      cnt_q          <= '0;
      lock_q         <= 1'b0;
      o_value        <= '0;
      o_digit_valid  <= '0;
      o_update       <= 1'b0;
      o_error        <= 1'b0;
      o_error_sticky <= 1'b0;
    end else begin
      p_q <= s_q;
      s_q <= in_w;
      if (in_w != s_q) begin
        cnt_q  <= '0;
        lock_q <= 1'b0;
      end else begin
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CW'(1);
        if (accept) lock_q <= 1'b1;
      end

      o_update <= accept;
      o_error  <= accept && !legal && !blank;
      if (accept && !legal && !blank) o_error_sticky <= 1'b1;

      if (accept) begin
        if (legal) begin
          o_value[4*idx +: 4] <= nibble;
          o_digit_valid[idx]  <= 1'b1;
        end else if (blank) begin
          o_value[4*idx +: 4] <= 4'h0;
          o_digit_valid[idx]  <= 1'b0;
        end else begin
          o_digit_valid[idx]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Directed bench for seg7_capture_decoder with NUM_DIGITS=4, STABLE_CYCLES=4.
module tb_seg7_capture_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = 7'h00;
  logic [3:0]  sel = 4'h0;
  logic [15:0] value;
  logic [3:0]  valid;
  logic        update;
  logic        error;
  logic        sticky;

  int checks = 0;
  int errors = 0;

  seg7_capture_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_seg_gfedcba  (seg),
    .i_digit_sel    (sel),
    .o_value        (value),
    .o_digit_valid  (valid),
    .o_update       (update),
    .o_error        (error),
    .o_error_sticky (sticky)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n, output int ups, output int errs);
    ups = 0;
    errs = 0;
    repeat (n) begin
      step();
      if (update) ups++;
      if (error) errs++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sel = 4'h0;
    seg = 7'h00;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sel = 4'h0;
    seg = 7'h00;
    step();
    step();
    checks++;
    if ({value, valid, update, error, sticky} !== 23'h0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", {value, valid, update, error, sticky});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({value, valid, update, error, sticky} !== 23'h0) begin
        errors++;
        $display("FAIL idle_zero cycle %0d: got %h expected 0", i, {value, valid, update, error, sticky});
      end
    end
  endtask

  task automatic test_single();
    int ups, errs;
    do_reset();
    sel = 4'b0010;
    seg = 7'h5B;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (update !== 1'b0) begin
        errors++;
        $display("FAIL single_early_update cycle %0d: got %b expected 0", i, update);
      end
    end
    step();
    checks++;
    if (update !== 1'b1) begin
      errors++;
      $display("FAIL single_update: got %b expected 1", update);
    end
    checks++;
    if (value[7:4] !== 4'h2) begin
      errors++;
      $display("FAIL single_value: got %h expected 2", value[7:4]);
    end
    checks++;
    if (valid !== 4'b0010) begin
      errors++;
      $display("FAIL single_valid: got %b expected 0010", valid);
    end
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL single_error: got %b expected 0", error);
    end
    hold(8, ups, errs);
    checks++;
    if (ups !== 0) begin
      errors++;
      $display("FAIL single_no_repeat: got %0d pulses expected 0", ups);
    end
  endtask

  task automatic test_scan();
    logic [6:0] codes [4];
    int ups, errs, total;
    codes[0] = 7'h6D;
    codes[1] = 7'h07;
    codes[2] = 7'h79;
    codes[3] = 7'h3F;
    total = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sel = 4'(1 << i);
      seg = codes[i];
      hold(5, ups, errs);
      total += ups;
    end
    checks++;
    if (total !== 4) begin
      errors++;
      $display("FAIL scan_updates: got %0d expected 4", total);
    end
    checks++;
    if (value !== 16'h0E75) begin
      errors++;
      $display("FAIL scan_value: got %h expected 0e75", value);
    end
    checks++;
    if (valid !== 4'hF) begin
      errors++;
      $display("FAIL scan_valid: got %b expected 1111", valid);
    end
    checks++;
    if (sticky !== 1'b0) begin
      errors++;
      $display("FAIL scan_sticky: got %b expected 0", sticky);
    end
  endtask

  task automatic test_error();
    int ups, errs;
    do_reset();
    sel = 4'b0001;
    seg = 7'h6D;
    hold(5, ups, errs);
    seg = 7'h01;
    repeat (4) step();
    step();
    checks++;
    if ({update, error, sticky} !== 3'b111) begin
      errors++;
      $display("FAIL illegal_pulse: got upd/err/sticky %b expected 111", {update, error, sticky});
    end
    checks++;
    if (value[3:0] !== 4'h5) begin
      errors++;
      $display("FAIL illegal_value_held: got %h expected 5", value[3:0]);
    end
    checks++;
    if (valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL illegal_valid: got %b expected 0", valid[0]);
    end
    step();
    checks++;
    if ({error, sticky} !== 2'b01) begin
      errors++;
      $display("FAIL illegal_one_cycle: got err/sticky %b expected 01", {error, sticky});
    end
    seg = 7'h00;
    hold(6, ups, errs);
    checks++;
    if (ups !== 1 || errs !== 0) begin
      errors++;
      $display("FAIL blank_pulses: got upd %0d err %0d expected 1 0", ups, errs);
    end
    checks++;
    if (value[3:0] !== 4'h0 || valid[0] !== 1'b0 || sticky !== 1'b1) begin
      errors++;
      $display("FAIL blank_state: got val %h vld %b sticky %b expected 0 0 1", value[3:0], valid[0], sticky);
    end
  endtask

  task automatic test_unstable();
    int u1, u2, u3, errs;
    do_reset();
    sel = 4'b0001;
    seg = 7'h6D;
    hold(5, u1, errs);
    sel = 4'b0100;
    seg = 7'h7F;
    hold(3, u1, errs);
    sel = 4'b0110;
    hold(10, u2, errs);
    sel = 4'b0000;
    hold(10, u3, errs);
    checks++;
    if (u1 + u2 + u3 !== 0) begin
      errors++;
      $display("FAIL unstable_updates: got %0d expected 0", u1 + u2 + u3);
    end
    checks++;
    if (value !== 16'h0005 || valid !== 4'b0001) begin
      errors++;
      $display("FAIL unstable_outputs: got val %h vld %b expected 0005 0001", value, valid);
    end
  endtask

  task automatic test_glitch();
    int u1, u2, u3, u4, errs;
    do_reset();
    sel = 4'b0100;
    seg = 7'h7D;
    hold(5, u1, errs);
    hold(4, u2, errs);
    seg = 7'h7F;
    hold(2, u3, errs);
    seg = 7'h7D;
    hold(5, u4, errs);
    checks++;
    if (u1 !== 1 || u2 !== 0 || u3 !== 0 || u4 !== 1) begin
      errors++;
      $display("FAIL glitch_pulses: got %0d %0d %0d %0d expected 1 0 0 1", u1, u2, u3, u4);
    end
    checks++;
    if (value !== 16'h0600 || valid !== 4'b0100) begin
      errors++;
      $display("FAIL glitch_outputs: got val %h vld %b expected 0600 0100", value, valid);
    end
  endtask

  task automatic test_reset_on_accept();
    int ups, errs;
    do_reset();
    sel = 4'b0001;
    seg = 7'h7D;
    hold(5, ups, errs);
    sel = 4'b0010;
    seg = 7'h77;
    repeat (4) step();
    checks++;
    if (update !== 1'b0 || value !== 16'h0006) begin
      errors++;
      $display("FAIL pre_accept: got upd %b val %h expected 0 0006", update, value);
    end
    rst_n = 1'b0;
    sel = 4'h0;
    seg = 7'h00;
    step();
    checks++;
    if ({value, valid, update, error, sticky} !== 23'h0) begin
      errors++;
      $display("FAIL reset_on_accept: got %h expected 0", {value, valid, update, error, sticky});
    end
    rst_n = 1'b1;
    hold(12, ups, errs);
    checks++;
    if (ups !== 0 || value !== 16'h0 || valid !== 4'h0) begin
      errors++;
      $display("FAIL after_reset: got upd %0d val %h vld %b expected 0 0 0", ups, value, valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_scan();
    test_error();
    test_unstable();
    test_glitch();
    test_reset_on_accept();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
